timer_sched: RTL



---
 rtl/timer_sched_pkg.sv | 14 +
 rtl/timer.sv | 27 ++
 rtl/timer_sched_psc.sv | 30 +++
 rtl/timer_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer sequencing controller.
package timer_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int          CNT_W         = 32;
   localparam int          DEF_PSC_W     = 16;
   localparam int          DEF_EXP_CNT_W = 8;
   localparam logic [31:0] RST_PERIOD    = 32'hFFFF_FFFF;

endpackage

// File: rtl/timer.sv
// 32-bit compare timer: counts on ena, raises a sticky tick one cycle after value==cmp.
module timer #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         ena_i,
   input  logic [W-1:0] cmp_value_i,
   output logic [W-1:0] value_o,
   output logic         tick_o
);

   // NOTE: registers are written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         value_o <= '0;
         tick_o  <= 1'b0;
      end else begin
         if (ena_i)
            value_o <= value_o + W'(1);
         if (value_o == cmp_value_i)
            tick_o <= 1'b1;
      end
   end

endmodule

// File: rtl/timer_sched_psc.sv
// Prescaler counter and count-enable gating for the compare timer.
module timer_psc
   import timer_sched_pkg::*;
#(
   parameter int PSC_W = DEF_PSC_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             pause_i,
   input  logic             clr_i,
   input  logic [PSC_W-1:0] psc_max_i,
   input  logic [CNT_W-1:0] count_i,
   input  logic [CNT_W-1:0] period_i,
   output logic             ena_o
);

   logic [PSC_W-1:0] psc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i)
         psc_q <= '0;
      else if (run_i && !pause_i)
         psc_q <= (psc_q == psc_max_i) ? '0 : psc_q + PSC_W'(1);
   end

   // The timer parks at the period value until the controller clears it.
   assign ena_o = run_i & ~pause_i & (psc_q == psc_max_i) & (count_i != period_i);

endmodule

// File: rtl/timer_sched.sv
// Sequences one compare timer for one-shot and periodic expiries with a sticky interrupt.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int PSC_W     = DEF_PSC_W,
   parameter int EXP_CNT_W = DEF_EXP_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 stop_i,
   input  logic                 pause_i,
   input  logic                 periodic_i,
   input  logic [31:0]          period_i,
   input  logic [PSC_W-1:0]     prescale_i,
   input  logic                 irq_ack_i,
   output logic                 busy_o,
   output logic [31:0]          count_o,
   output logic                 irq_o,
   output logic                 overrun_o,
   output logic                 done_o,
   output logic                 cfg_err_o,
   output logic [EXP_CNT_W-1:0] exp_cnt_o
);

   state_e           state_q;
   logic [CNT_W-1:0] period_q;
   logic [PSC_W-1:0] psc_max_q;
   logic             periodic_q;

   logic run;
   logic tick;
   logic ena;
   logic clr;
   logic start_ok;
   logic start_bad;
   logic stop_run;
   logic expiry;

   assign run    = (state_q == RUN);
   assign busy_o = run;

   // Priority: stop, then a valid (re)start, then expiry.
   always_comb begin
      start_ok  = start_i & (period_i != '0) & ~stop_i;
      start_bad = start_i & (period_i == '0);
      stop_run  = stop_i & run;
      expiry    = run & tick & ~stop_i & ~start_ok;
      clr       = start_ok | stop_run | expiry;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         period_q   <= RST_PERIOD;
         psc_max_q  <= '0;
         periodic_q <= 1'b0;
         irq_o      <= 1'b0;
         overrun_o  <= 1'b0;
         done_o     <= 1'b0;
         cfg_err_o  <= 1'b0;
         exp_cnt_o  <= '0;
      end else begin
         done_o <= 1'b0;

         if (start_bad)
            cfg_err_o <= 1'b1;

         if (stop_run) begin
            state_q <= IDLE;
         end else if (start_ok) begin
            period_q   <= period_i;
            psc_max_q  <= prescale_i;
            periodic_q <= periodic_i;
            exp_cnt_o  <= '0;
            cfg_err_o  <= 1'b0;
            state_q    <= RUN;
         end else if (expiry) begin
            exp_cnt_o <= exp_cnt_o + EXP_CNT_W'(1);
            if (!periodic_q) begin
               done_o  <= 1'b1;
               state_q <= IDLE;
            end
         end

         // A set in the same cycle as an acknowledge wins for the bit being set.
         if (expiry) begin
            irq_o <= 1'b1;
            if (irq_o && !irq_ack_i)
               overrun_o <= 1'b1;
            else if (irq_ack_i)
               overrun_o <= 1'b0;
         end else if (irq_ack_i) begin
            irq_o     <= 1'b0;
            overrun_o <= 1'b0;
         end
      end
   end

   timer #(
      .W (CNT_W)
   ) u_timer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (clr),
      .ena_i       (ena),
      .cmp_value_i (period_q),
      .value_o     (count_o),
      .tick_o      (tick)
   );

   timer_psc #(
      .PSC_W (PSC_W)
   ) u_psc (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .run_i     (run),
      .pause_i   (pause_i),
      .clr_i     (clr),
      .psc_max_i (psc_max_q),
      .count_i   (count_o),
      .period_i  (period_q),
      .ena_o     (ena)
   );

endmodule
